bidir_piso_tx: RTL and testbench
================================

Name: bidir_piso_tx

Overview:
- Parallel-in, serial-out transmitter that feeds our serial shift chains, such as the bidirectional SISO register.
- Accepts a WIDTH-bit word over a valid/ready handshake.
- Shifts the word out one bit per clock, LSB-first or MSB-first as selected per word.
- Flags frame completion so an upstream controller can stream words back-to-back.

Parameters:
- WIDTH, 4, data word width in bits; minimum 2.
- IDLE_LEVEL, 1'b0, value driven on serial_out when no frame is active.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- clear  input  1  reset, asynchronous, active-high; clears all state immediately.
- load_valid  input  1  upstream word valid.
- load_ready  output  1  transmitter can accept a word this cycle.
- load_data  input  WIDTH  word to transmit; sampled only on handshake.
- dir  input  1  1 = LSB-first (right-shift order), 0 = MSB-first (left-shift order); sampled only on handshake.
- serial_out  output  1  registered serial bit stream.
- busy  output  1  high while a frame is being shifted out.
- done  output  1  one-cycle pulse, concurrent with the final bit of a frame.

Behaviour:
- Reset (clear=1, async): state=IDLE, shift reg=0, bit count=0, serial_out=IDLE_LEVEL, load_ready=1, busy=0, done=0.
- Handshake: a word is accepted on a posedge where load_valid && load_ready. The upstream must hold load_data and dir stable while valid && !ready.
- States (FSM):
  - IDLE: load_ready=1, busy=0, serial_out=IDLE_LEVEL. On accept, latch data and dir, drive the first bit onto serial_out at the same edge, set count=1, go to SHIFT.
  - SHIFT: busy=1. Each posedge shifts the latched register toward the output end (dir=1: output q[0], shift right; dir=0: output q[WIDTH-1], shift left) and increments count.
- Latency: the first bit is visible in the cycle after the accepting edge. Each bit is held for exactly one clk. A frame occupies FRAME_LEN consecutive cycles (FRAME_LEN = WIDTH, or WIDTH+1 with the optional feature).
- Last-bit cycle (count==FRAME_LEN): done=1 and load_ready=1.
  - If a word is accepted at the closing edge: its first bit follows immediately with no gap, and the FSM stays in SHIFT.
  - Otherwise: go to IDLE, and serial_out returns to IDLE_LEVEL.
- Mid-frame: load_ready=0, and load_valid is ignored. Changes on dir or load_data do not affect the frame in flight.
- Reset mid-frame: the frame aborts, no done pulse, serial_out=IDLE_LEVEL immediately. Once clear is released, the first edge behaves as IDLE.
- Count width: $clog2(FRAME_LEN+1). It must never wrap inside a frame.
- All outputs are registered except load_ready, which is decoded from state and count.

Optional Feature:
- Macro: BIDIR_PISO_PARITY_EN.
- When defined: an even-parity bit (XOR of all data bits) is appended after the last data bit, regardless of dir, and FRAME_LEN=WIDTH+1. done and load_ready move to the parity-bit cycle.
- When undefined: FRAME_LEN=WIDTH, with no parity logic or extra count bit.

Decomposition:
- Package bidir_piso_pkg:
  - typedef enum logic {IDLE, SHIFT} piso_state_t.
  - Constants DIR_LSB_FIRST=1'b1 and DIR_MSB_FIRST=1'b0.
  - Function even_parity over a WIDTH-bit vector.
- One sub-module, piso_shreg: holds the WIDTH-bit load/shift datapath (load, dir-selected shift, output-bit select). The FSM, counter and handshake stay in the top module.

Test Plan (WIDTH=4, IDLE_LEVEL=0):
- Reset check: clear=1 asynchronously between edges -> serial_out=0, load_ready=1, busy=0, done=0 with no clock edge required.
- LSB-first: dir=1, load 4'b1011 -> serial_out 1,1,0,1 on cycles 1-4 after accept; busy=1 on cycles 1-4; done only on cycle 4; serial_out=0 on cycle 5.
- MSB-first: dir=0, load 4'b1011 -> 1,0,1,1; done on cycle 4.
- Back-to-back: load_valid held high, dir=1, words 4'b0001 then 4'b1110 -> 8 contiguous bits 1,0,0,0,0,1,1,1; load_ready high only on cycles 4 and 8; done on cycles 4 and 8.
- Abort: clear pulsed during bit 2 of 4'b1111 -> serial_out=0 immediately, no done; after release, a new 4'b0101 with dir=1 transmits 1,0,1,0 cleanly.
- Parity (BIDIR_PISO_PARITY_EN): dir=1, 4'b0111 -> 1,1,1,0 then parity 1; done on cycle 5.

Source files
------------

// File: rtl/bidir_piso_pkg.sv
// Shared types, direction constants and parity helper for the bidirectional PISO transmitter.
package bidir_piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  localparam logic DIR_LSB_FIRST = 1'b1;
  localparam logic DIR_MSB_FIRST = 1'b0;

  // Widest word the parity helper accepts; callers zero-extend into it.
  localparam int unsigned PARITY_MAX_W = 64;

  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// Load/shift datapath for the PISO transmitter; out_bit_c is the bit that the
// current load or shift moves onto the serial line.
module piso_shreg
  import bidir_piso_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load_en,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_dir,
  output logic             out_bit_c
);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] src_c;
  logic             dir_q, dir_d;
  logic             dsel_c;

  // On load the incoming word is used directly so its first bit leaves at the accepting edge.
  always_comb begin
    src_c     = load_en ? load_data : shreg_q;
    dsel_c    = load_en ? load_dir : dir_q;
    out_bit_c = (dsel_c == DIR_MSB_FIRST) ? src_c[WIDTH-1] : src_c[0];
    shreg_d   = shreg_q;
    dir_d     = dir_q;
    if (load_en || shift_en) begin
      shreg_d = (dsel_c == DIR_LSB_FIRST) ? (src_c >> 1) : (src_c << 1);
      dir_d   = dsel_c;
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      shreg_q <= '0;
      dir_q   <= DIR_LSB_FIRST;
    end else begin
      shreg_q <= shreg_d;
      dir_q   <= dir_d;
    end
  end

endmodule

// File: rtl/bidir_piso_tx.sv
// Parallel-in serial-out transmitter with per-word shift direction and back-to-back framing.
// Optional even-parity trailer bit enabled by defining BIDIR_PISO_PARITY_EN.
module bidir_piso_tx
  import bidir_piso_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             dir,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

`ifdef BIDIR_PISO_PARITY_EN
  localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
  localparam int unsigned FRAME_LEN = WIDTH;
`endif
  localparam int unsigned        CNT_W    = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(FRAME_LEN);
`ifdef BIDIR_PISO_PARITY_EN
  localparam logic [CNT_W-1:0]   CNT_DATA_LAST = CNT_W'(WIDTH);
`endif

  piso_state_t      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             serial_q, serial_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept_c;
  logic             load_en_c;
  logic             shift_en_c;
  logic             shreg_bit_c;
`ifdef BIDIR_PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif

  piso_shreg #(
    .WIDTH (WIDTH)
  ) u_shreg (
    .clk       (clk),
    .clear     (clear),
    .load_en   (load_en_c),
    .shift_en  (shift_en_c),
    .load_data (load_data),
    .load_dir  (dir),
    .out_bit_c (shreg_bit_c)
  );

  // count_q is the 1-based index of the bit currently on serial_out; 0 when idle.
  always_comb begin
    load_ready = (state_q == IDLE) || (count_q == CNT_LAST);
    accept_c   = load_valid && load_ready;
    state_d    = IDLE;
    count_d    = '0;
    serial_d   = IDLE_LEVEL;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    load_en_c  = 1'b0;
    shift_en_c = 1'b0;
`ifdef BIDIR_PISO_PARITY_EN
    parity_d   = parity_q;
`endif
    if (accept_c) begin
      state_d   = SHIFT;
      count_d   = CNT_W'(1);
      load_en_c = 1'b1;
      serial_d  = shreg_bit_c;
      busy_d    = 1'b1;
`ifdef BIDIR_PISO_PARITY_EN
      parity_d  = even_parity(PARITY_MAX_W'(load_data));
`endif
    end else if ((state_q == SHIFT) && (count_q != CNT_LAST)) begin
      state_d = SHIFT;
      count_d = count_q + CNT_W'(1);
      busy_d  = 1'b1;
      done_d  = (count_d == CNT_LAST);
`ifdef BIDIR_PISO_PARITY_EN
      if (count_q == CNT_DATA_LAST) begin
        serial_d = parity_q;
      end else begin
        shift_en_c = 1'b1;
        serial_d   = shreg_bit_c;
      end
`else
      shift_en_c = 1'b1;
      serial_d   = shreg_bit_c;
`endif
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q  <= IDLE;
      count_q  <= '0;
      serial_q <= IDLE_LEVEL;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef BIDIR_PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef BIDIR_PISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign serial_out = serial_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_bidir_piso_tx.sv
// Bench for bidir_piso_tx: directed frames plus randomized traffic against a bit-queue model.
module tb_bidir_piso_tx;

  localparam int unsigned W          = 4;
  localparam logic        IDLE_LEVEL = 1'b0;
`ifdef BIDIR_PISO_PARITY_EN
  localparam int unsigned FL = W + 1;
`else
  localparam int unsigned FL = W;
`endif

  logic         clk;
  logic         clear;
  logic         tb_valid;
  logic         load_ready;
  logic [W-1:0] tb_data;
  logic         tb_dir;
  logic         serial_out;
  logic         busy;
  logic         done;

  int n_tests;
  int n_fail;

  // Model: one entry per future serial cycle, {bit, last_of_frame}.
  logic [1:0]   m_q[$];
  logic         cur_v;
  logic         cur_bit;
  logic         cur_last;
  logic [31:0]  cap;

  bidir_piso_tx #(
    .WIDTH      (W),
    .IDLE_LEVEL (IDLE_LEVEL)
  ) dut (
    .clk        (clk),
    .clear      (clear),
    .load_valid (tb_valid),
    .load_ready (load_ready),
    .load_data  (tb_data),
    .dir        (tb_dir),
    .serial_out (serial_out),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_q.delete();
    cur_v    = 1'b0;
    cur_bit  = 1'b0;
    cur_last = 1'b0;
  endtask

  task automatic m_advance(input logic acc, input logic [W-1:0] d, input logic dr);
    logic [1:0] e;
    if (acc) begin
      for (int i = 0; i < W; i++) begin
        e[1] = dr ? d[i] : d[W-1-i];
        e[0] = (FL == W) && (i == W - 1);
        m_q.push_back(e);
      end
      if (FL != W) m_q.push_back({^d, 1'b1});
    end
    if (m_q.size() > 0) begin
      e        = m_q.pop_front();
      cur_v    = 1'b1;
      cur_bit  = e[1];
      cur_last = e[0];
    end else begin
      cur_v    = 1'b0;
      cur_bit  = 1'b0;
      cur_last = 1'b0;
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_serial"}, 32'(serial_out), 32'(IDLE_LEVEL));
    check_eq({tag, "_ready"},  32'(load_ready), 32'd1);
    check_eq({tag, "_busy"},   32'(busy),       32'd0);
    check_eq({tag, "_done"},   32'(done),       32'd0);
  endtask

  // One clock: model steps on the edge, DUT outputs compared on the following negedge.
  task automatic step(output logic acc);
    logic rdy;
    @(posedge clk);
    rdy = !cur_v || cur_last;
    acc = tb_valid && rdy;
    m_advance(acc, tb_data, tb_dir);
    @(negedge clk);
    check_eq("serial", 32'(serial_out), 32'(cur_v ? cur_bit : IDLE_LEVEL));
    check_eq("busy",   32'(busy),       32'(cur_v));
    check_eq("done",   32'(done),       32'(cur_v && cur_last));
    check_eq("ready",  32'(load_ready), 32'(!cur_v || cur_last));
    cap = {cap[30:0], serial_out};
  endtask

  task automatic run_seq(input logic [W-1:0] w0, input logic d0,
                         input logic [W-1:0] w1, input logic d1,
                         input int nwords, input int nsteps);
    int   idx;
    logic acc;
    idx = 0;
    cap = '0;
    for (int s = 0; s < nsteps; s++) begin
      if (idx < nwords) begin
        tb_valid = 1'b1;
        tb_data  = (idx == 0) ? w0 : w1;
        tb_dir   = (idx == 0) ? d0 : d1;
      end else begin
        tb_valid = 1'b0;
        tb_data  = W'($urandom);
        tb_dir   = 1'($urandom);
      end
      step(acc);
      if (acc) idx++;
    end
    tb_valid = 1'b0;
  endtask

  initial begin
    logic acc;
    logic pend;
    n_tests  = 0;
    n_fail   = 0;
    cap      = '0;
    tb_valid = 1'b0;
    tb_data  = '0;
    tb_dir   = 1'b1;
    clear    = 1'b0;
    m_reset();

    #1 clear = 1'b1;
    #1 check_idle("reset_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    check_idle("reset_release");

    run_seq(4'b1011, 1'b1, 4'b0000, 1'b0, 1, FL + 1);
`ifdef BIDIR_PISO_PARITY_EN
    check_eq("lsb_seq", cap, 32'h36);
`else
    check_eq("lsb_seq", cap, 32'h1A);
`endif

    run_seq(4'b1011, 1'b0, 4'b0000, 1'b0, 1, FL + 1);
`ifdef BIDIR_PISO_PARITY_EN
    check_eq("msb_seq", cap, 32'h2E);
`else
    check_eq("msb_seq", cap, 32'h16);
`endif

    run_seq(4'b0001, 1'b1, 4'b1110, 1'b1, 2, 2 * FL + 1);
`ifdef BIDIR_PISO_PARITY_EN
    check_eq("b2b_seq", cap, 32'h45E);
`else
    check_eq("b2b_seq", cap, 32'h10E);
`endif

    // Abort during bit 2, then a clean frame after release.
    run_seq(4'b1111, 1'b1, 4'b0000, 1'b0, 1, 2);
    clear = 1'b1;
    #1 check_idle("abort");
    m_reset();
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    run_seq(4'b0101, 1'b1, 4'b0000, 1'b0, 1, FL + 1);
`ifdef BIDIR_PISO_PARITY_EN
    check_eq("post_abort_seq", cap, 32'h28);
`else
    check_eq("post_abort_seq", cap, 32'h14);
`endif

    run_seq(4'b0111, 1'b1, 4'b0000, 1'b0, 1, FL + 1);
`ifdef BIDIR_PISO_PARITY_EN
    check_eq("parity_seq", cap, 32'h3A);
`else
    check_eq("parity_seq", cap, 32'h1C);
`endif

    // Random traffic; data/dir held while a word waits for ready.
    pend = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!pend) begin
        tb_valid = ($urandom_range(0, 3) != 0);
        tb_data  = W'($urandom);
        tb_dir   = 1'($urandom);
      end
      step(acc);
      pend = tb_valid && !acc;
      if ($urandom_range(0, 149) == 0) begin
        clear = 1'b1;
        #1 check_idle("rand_clear");
        m_reset();
        #1 clear = 1'b0;
        pend = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
